// File: rtl/control_fsm.sv
// Multi-cycle control sequencer: fetches into IR, steps FETCH/DECODE/EXEC/MEM/WB/HALT, drives ALU/memory enables.
// Optional retired-instruction counter is built only when CONTROL_INSTR_COUNT_EN is defined.
module control_fsm #(
   parameter logic [7:0] PC_RESET = 8'h00,
   parameter int         COUNT_W  = 16
) (
   input  logic               clk,
   input  logic               Clear,
   input  logic               Run,
   input  logic               Step,
   input  logic [7:0]         Instr,
   output logic [7:0]         PC,
   output logic [7:0]         IR,
   output logic [2:0]         state,
   output logic               ALUOp,
   output logic               RegWrite,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               Halted,
   output logic [COUNT_W-1:0] InstrCount
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_LW  = 2'b01;
   localparam logic [1:0] OP_SW  = 2'b10;
   localparam logic [1:0] OP_JMP = 2'b11;

   localparam logic [7:0] HALT_INSTR = 8'hFF;

   logic [2:0] state_reg, state_next;
   logic [7:0] pc_reg, pc_next;
   logic [7:0] ir_reg, ir_next;
   logic       step_d_reg;
   logic       step_pulse;
   logic [1:0] op;
   logic [7:0] jmp_off;

   assign step_pulse = Step & ~step_d_reg;
   assign op         = ir_reg[7:6];
   assign jmp_off    = {{2{ir_reg[5]}}, ir_reg[5:0]};

   always_ff @(posedge clk) begin
      if (Clear) begin
         state_reg  <= S_FETCH;
         pc_reg     <= PC_RESET;
         ir_reg     <= 8'h00;
         step_d_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         ir_reg     <= ir_next;
         step_d_reg <= Step;
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      ir_next    = ir_reg;
      case (state_reg)
         S_FETCH: begin
            // Step edges seen outside FETCH are simply dropped, never queued.
            if (Run || step_pulse) begin
               ir_next    = Instr;
               pc_next    = pc_reg + 8'd1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: state_next = (ir_reg == HALT_INSTR) ? S_HALT : S_EXEC;
         S_EXEC: begin
            case (op)
               OP_ADD:  state_next = S_WB;
               OP_LW:   state_next = S_MEM;
               OP_SW:   state_next = S_MEM;
               default: begin
                  pc_next    = pc_reg + jmp_off;
                  state_next = S_FETCH;
               end
            endcase
         end
         S_MEM:   state_next = (op == OP_LW) ? S_WB : S_FETCH;
         S_WB:    state_next = S_FETCH;
         S_HALT:  state_next = S_HALT;
         default: state_next = S_FETCH;
      endcase
   end

   always_comb begin
      ALUOp    = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Halted   = 1'b0;
      case (state_reg)
         S_EXEC: ALUOp    = (op != OP_JMP);
         S_MEM: begin
            MemRead  = (op == OP_LW);
            MemWrite = (op == OP_SW);
         end
         S_WB:   RegWrite = (op == OP_ADD) || (op == OP_LW);
         S_HALT: Halted   = 1'b1;
         default: ;
      endcase
   end

   assign PC    = pc_reg;
   assign IR    = ir_reg;
   assign state = state_reg;

`ifdef CONTROL_INSTR_COUNT_EN
   logic               retire;
   logic [COUNT_W-1:0] count_reg;

   // Retire is the last cycle of each instruction: JMP in EXEC, SW in MEM, ADD/LW in WB.
   assign retire = ((state_reg == S_EXEC) && (op == OP_JMP)) ||
                   ((state_reg == S_MEM)  && (op == OP_SW))  ||
                    (state_reg == S_WB);

   always_ff @(posedge clk) begin
      if (Clear) begin
         count_reg <= '0;
      end else if (retire && (count_reg != '1)) begin
         count_reg <= count_reg + COUNT_W'(1);
      end
   end

   assign InstrCount = count_reg;
`else
   assign InstrCount = '0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: a per-instruction reference model pushes expected traces, a monitor pops them.
module tb_control_fsm;

   typedef struct {
      logic [7:0]  ir;
      logic [7:0]  pc;
      int          n;
      logic [31:0] steps;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        clr, run, step;
   logic [7:0]  instr, pc, ir;
   logic [2:0]  state;
   logic        alu_op, reg_write, mem_read, mem_write, halted;
   logic [15:0] instr_count;

   logic [7:0]  mem [256];
   exp_t        exp_q [$];
   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   logic        mon_en = 1'b0;
   logic [7:0]  m_pc;
   logic [15:0] m_cnt;

   always #5 clk = ~clk;
   assign instr = mem[pc];

   control_fsm dut (
      .clk(clk), .Clear(clr), .Run(run), .Step(step), .Instr(instr),
      .PC(pc), .IR(ir), .state(state), .ALUOp(alu_op), .RegWrite(reg_write),
      .MemRead(mem_read), .MemWrite(mem_write), .Halted(halted), .InstrCount(instr_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [7:0] mk(input logic [2:0] st, input logic a, input logic rw,
                                     input logic mr, input logic mw, input logic h);
      return {st, a, rw, mr, mw, h};
   endfunction

   // Reference: what one instruction at m_pc should do, from the opcode rules alone.
   task automatic push_instr();
      exp_t       e;
      logic [7:0] ins;
      logic [7:0] nxt;
      logic       retires;
      ins     = mem[m_pc];
      nxt     = m_pc + 8'd1;
      retires = 1'b1;
      e.ir    = ins;
      e.pc    = nxt;
      e.steps = '0;
      e.steps[7:0] = mk(3'd1, 0, 0, 0, 0, 0);
      if (ins == 8'hFF) begin
         e.n = 2; e.steps[15:8] = mk(3'd5, 0, 0, 0, 0, 1); retires = 1'b0;
      end else begin
         case (ins[7:6])
            2'd0: begin
               e.n = 3; e.steps[15:8] = mk(3'd2, 1, 0, 0, 0, 0); e.steps[23:16] = mk(3'd4, 0, 1, 0, 0, 0);
            end
            2'd1: begin
               e.n = 4; e.steps[15:8] = mk(3'd2, 1, 0, 0, 0, 0); e.steps[23:16] = mk(3'd3, 0, 0, 1, 0, 0);
               e.steps[31:24] = mk(3'd4, 0, 1, 0, 0, 0);
            end
            2'd2: begin
               e.n = 3; e.steps[15:8] = mk(3'd2, 1, 0, 0, 0, 0); e.steps[23:16] = mk(3'd3, 0, 0, 0, 1, 0);
            end
            default: begin
               e.n = 2; e.steps[15:8] = mk(3'd2, 0, 0, 0, 0, 0);
               e.pc = nxt + {{2{ins[5]}}, ins[5:0]};
            end
         endcase
      end
      if (retires && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`ifdef CONTROL_INSTR_COUNT_EN
      e.cnt = m_cnt;
`else
      e.cnt = 16'h0000;
`endif
      m_pc = e.pc;
      exp_q.push_back(e);
   endtask

   // Monitor: collects one trace per instruction (DECODE up to FETCH or HALT) and pops the scoreboard.
   initial begin
      logic        inflight;
      int          n;
      logic [31:0] acc;
      logic [7:0]  ir_s;
      logic [7:0]  cur;
      exp_t        e;
      inflight = 1'b0; n = 0; acc = '0; ir_s = '0;
      forever begin
         @(negedge clk);
         cur = {state, alu_op, reg_write, mem_read, mem_write, halted};
         if (!mon_en) begin
            inflight = 1'b0;
         end else begin
            if (!inflight && state == 3'd1) begin
               inflight = 1'b1; n = 0; acc = '0; ir_s = ir;
            end
            if (inflight) begin
               if (state == 3'd0 || state == 3'd5) begin
                  if (state == 3'd5) begin
                     if (n < 4) acc[n*8 +: 8] = cur;
                     n++;
                  end else begin
                     chk("fetch_outs", {24'h0, cur}, 32'h0);
                  end
                  if (exp_q.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL unexpected_instr actual ir=%0h required none", ir_s);
                  end else begin
                     e = exp_q.pop_front();
                     chk("ir", {24'h0, ir_s}, {24'h0, e.ir});
                     chk("pc", {24'h0, pc}, {24'h0, e.pc});
                     chk("nsteps", n, e.n);
                     chk("steps", acc, e.steps);
                     chk("count", {16'h0, instr_count}, {16'h0, e.cnt});
                  end
                  $display("instr ir=%0h pc_after=%0h cycles=%0d count=%0d", ir_s, pc, n + 1, instr_count);
                  done_cnt++;
                  inflight = 1'b0;
               end else begin
                  if (n < 4) acc[n*8 +: 8] = cur;
                  n++;
               end
            end
         end
      end
   end

   task automatic wait_done(input int target, input int budget, input string name);
      int k;
      k = 0;
      while (done_cnt < target && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      if (done_cnt < target) begin
         checks++; errors++;
         $display("FAIL %s_timeout actual done=%0d required %0d", name, done_cnt, target);
      end
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string name);
      int k;
      k = 0;
      while (state !== s && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      if (state !== s) begin
         checks++; errors++;
         $display("FAIL %s_timeout actual state=%0d required %0d", name, state, s);
      end
   endtask

   task automatic run_prog(input int n, input string name);
      int target;
      target = done_cnt + n;
      for (int i = 0; i < n; i++) push_instr();
      run = 1'b1;
      wait_done(target, n * 6 + 20, name);
      run = 1'b0;
      chk({name, "_drained"}, exp_q.size(), 0);
   endtask

   task automatic do_clear();
      @(negedge clk); #1;
      clr = 1'b1;
      @(negedge clk); #1;
      clr = 1'b0;
      m_pc = 8'h00; m_cnt = 16'h0;
   endtask

   initial begin
      logic [7:0] v;
      logic [7:0] pc_hold;
      logic [7:0] ir_hold;
      int         d0;
      clr = 1'b1; run = 1'b0; step = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h1B;
      m_pc = 8'h00; m_cnt = 16'h0;
      repeat (2) @(negedge clk);
      #1 clr = 1'b0;
      chk("rst_pc", {24'h0, pc}, 32'h0);
      chk("rst_ir", {24'h0, ir}, 32'h0);
      chk("rst_state", {29'h0, state}, 32'h0);
      chk("rst_outs", {27'h0, alu_op, reg_write, mem_read, mem_write, halted}, 32'h0);
      chk("rst_count", {16'h0, instr_count}, 32'h0);

      // Directed program: ADD, LW, SW, JMP to 0x10, JMP -2 to 0x0F, ADD.
      mem[8'h00] = 8'h1B; mem[8'h01] = 8'h46; mem[8'h02] = 8'h89;
      mem[8'h03] = 8'hCC; mem[8'h10] = 8'hFE; mem[8'h0F] = 8'h1B;
      mon_en = 1'b1;
      run_prog(6, "directed");

      for (int i = 0; i < 256; i++) begin
         v = 8'($urandom_range(0, 255));
         mem[i] = (v == 8'hFF) ? 8'h1B : v;
      end
      run_prog(40, "random");

      pc_hold = pc; ir_hold = ir;
      repeat (5) @(negedge clk);
      #1;
      chk("stall_pc", {24'h0, pc}, {24'h0, pc_hold});
      chk("stall_ir", {24'h0, ir}, {24'h0, ir_hold});
      chk("stall_state", {29'h0, state}, 32'h0);

      d0 = done_cnt;
      push_instr();
      step = 1'b1;
      repeat (10) @(negedge clk);
      #1 step = 1'b0;
      chk("step_held_count", done_cnt, d0 + 1);
      chk("step_held_state", {29'h0, state}, 32'h0);

      d0 = done_cnt;
      mem[m_pc] = 8'h1B;
      push_instr();
      @(negedge clk); #1 step = 1'b1;
      @(negedge clk); #1 step = 1'b0;
      wait_state(3'd2, 10, "step_exec");
      step = 1'b1;
      @(negedge clk); #1 step = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      chk("step_exec_ignored", done_cnt, d0 + 1);
      chk("step_exec_pc", {24'h0, pc}, {24'h0, m_pc});
      chk("step_exec_drained", exp_q.size(), 0);

      mem[m_pc] = 8'hFF;
      push_instr();
      run = 1'b1;
      wait_state(3'd5, 10, "halt");
      pc_hold = pc;
      for (int i = 0; i < 20; i++) begin
         step = ~step;
         @(negedge clk); #1;
         chk("halt_pc", {24'h0, pc}, {24'h0, pc_hold});
         chk("halt_flag", {28'h0, halted, state}, {28'h0, 1'b1, 3'd5});
      end
      step = 1'b0; run = 1'b0;
      chk("halt_drained", exp_q.size(), 0);
      do_clear();
      chk("clr_halt_state", {29'h0, state}, 32'h0);
      chk("clr_halt_pc", {24'h0, pc}, 32'h0);
      chk("clr_halt_ir_flag", {23'h0, ir, halted}, 32'h0);
      chk("clr_halt_count", {16'h0, instr_count}, 32'h0);

      // Clear landing in the MEM state of a LW must cancel it, including the RegWrite.
      mon_en = 1'b0;
      mem[8'h00] = 8'h46;
      @(negedge clk); #1 run = 1'b1;
      wait_state(3'd3, 10, "lw_mem");
      clr = 1'b1; run = 1'b0;
      @(negedge clk); #1;
      chk("clr_mem_state", {29'h0, state}, 32'h0);
      chk("clr_mem_count", {16'h0, instr_count}, 32'h0);
      chk("clr_mem_regwrite", {31'h0, reg_write}, 32'h0);
      clr = 1'b0;
      @(negedge clk); #1;
      chk("clr_mem_after", {28'h0, state, reg_write}, 32'h0);
      m_pc = 8'h00; m_cnt = 16'h0;

      mem[8'h00] = 8'h1B; mem[8'h01] = 8'h1B; mem[8'h02] = 8'h1B; mem[8'h03] = 8'hDC;
      mon_en = 1'b1;
      run_prog(4, "count");
`ifdef CONTROL_INSTR_COUNT_EN
      chk("count_total", {16'h0, instr_count}, 32'd4);
`else
      chk("count_total", {16'h0, instr_count}, 32'd0);
`endif
      chk("count_pc", {24'h0, pc}, 32'h20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multi-cycle control sequencer sitting directly upstream of the 8-bit ALU and register file.
- Fetches an 8-bit instruction at PC, latches it in IR, and steps the 3-bit state code that the ALU and datapath consume.
- Drives ALUOp, RegWrite, MemRead and MemWrite, and performs PC update (increment or relative jump).
- Supports free-run and single-step operation, and halts on a dedicated HALT encoding.

Parameters:
- PC_RESET, 8'h00, PC value loaded on Clear.
- COUNT_W, 16, width of the retired-instruction counter (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- Clear  input  1  synchronous, active-high reset.
- Run  input  1  1 = free-run; 0 = single-step mode.
- Step  input  1  single-step request; only its rising edge is used.
- Instr  input  8  instruction-memory read data at address PC (combinational memory).
- PC  output  8  program counter.
- IR  output  8  instruction register.
- state  output  3  current state code: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT.
- ALUOp  output  1  1 = ALU adds Data1+Data2; 0 = ALU outputs 0.
- RegWrite  output  1  register-file write enable.
- MemRead  output  1  data-memory read enable.
- MemWrite  output  1  data-memory write enable.
- Halted  output  1  1 while state==HALT.
- InstrCount  output  COUNT_W  number of retired instructions.

Behaviour:
- Clock is clk. Reset is Clear, synchronous and active-high.
- On Clear, all of the following take effect on the next edge:
  - PC=PC_RESET, IR=0, state=FETCH, step-edge register=0, InstrCount=0.
  - All enable outputs are 0 and Halted=0.
- Clear has priority over every other event in every state, including HALT and mid-instruction.
- Instruction format: [7:6] op, [5:4] rs, [3:2] rt, [1:0] rd.
- Opcodes:
  - 00 ADD
  - 01 LW
  - 10 SW
  - 11 JMP, offset = sign-extended IR[5:0]
- 8'hFF is HALT; it is not treated as a jump.
- Step edge detection: step_pulse = Step & ~Step_d, where Step_d is registered every cycle.
- FETCH:
  - Advances only if Run=1 or step_pulse=1; otherwise it holds with PC and IR unchanged.
  - On advance: IR<=Instr, PC<=PC+1 (8-bit wrap, 8'hFF->8'h00), state<=DECODE.
- DECODE: unconditional transition to EXEC.
  - If IR==8'hFF: go to HALT instead.
- EXEC (state==2):
  - ALUOp=1 for ADD, LW and SW; 0 for JMP.
  - JMP: PC<=PC+sext(IR[5:0]) with 8-bit wrap, then state<=FETCH; the instruction retires here.
  - ADD: go to WB.
  - LW and SW: go to MEM.
- MEM:
  - LW: MemRead=1, then go to WB.
  - SW: MemWrite=1, then go to FETCH; the instruction retires here.
- WB: RegWrite=1 for ADD and LW, then go to FETCH; the instruction retires here.
- HALT:
  - Halted=1; state, PC and IR hold.
  - Leaves only via Clear.
  - Run and Step are ignored.
- Enable outputs are combinational decodes of state and IR (Moore style). They are 0 in every state except those listed above.
- Each enable is asserted for exactly one cycle per instruction.
- Latencies by instruction:
  - ADD: 4 cycles (F-D-E-W).
  - LW: 5 cycles (F-D-E-M-W).
  - SW: 4 cycles (F-D-E-M).
  - JMP: 3 cycles (F-D-E).
  - In every case, plus any stall cycles spent in FETCH.
- A Step held high yields exactly one instruction. A second instruction requires Step to go low and then high again.
- A Step edge that arrives while not in FETCH is lost, not queued.
- Switching Run from 1 to 0 mid-instruction: the current instruction completes, then the sequencer waits in FETCH.
- State codes 6 and 7 are illegal; if reached, the next state is FETCH.

Optional Feature:
- Macro: CONTROL_INSTR_COUNT_EN.
- When defined: InstrCount increments by 1 on each retire cycle (JMP in EXEC, SW in MEM, ADD and LW in WB).
  - The counter saturates at all-ones.
  - HALT does not count.
  - Clear zeroes it.
- When undefined: the counter logic is omitted and InstrCount is tied to 0.

Test Plan:
- Clear, then Run=1 with Instr=8'h1B (ADD): states 0,1,2,4; ALUOp=1 in state 2; RegWrite=1 for one cycle in state 4; PC goes 00->01.
- Run=1 with LW 8'h46 then SW 8'h89: LW takes 5 cycles with MemRead=1 in state 3 and RegWrite in state 4; SW takes 4 cycles with MemWrite=1 in state 3 and no RegWrite.
- JMP 8'hFE at PC=8'h10: PC becomes 8'h11 at FETCH, then 8'h0F at EXEC; ALUOp=0; back in FETCH after 3 cycles.
- Run=0 with Step held high for 10 cycles: exactly one instruction executes; a Step low-then-high sequence runs the next one; a Step pulse issued during EXEC is ignored.
- Instr=8'hFF: DECODE goes to HALT; Halted=1 and PC frozen for 20 cycles despite Run=1 and Step pulses; Clear returns to FETCH with PC=PC_RESET.
- With CONTROL_INSTR_COUNT_EN defined: 3 ADDs and 1 JMP give InstrCount=4; asserting Clear during the MEM state of a LW gives state=0 and InstrCount=0 on the next cycle, with no RegWrite pulse.
